// File: rtl/rv_regfile_mp.sv
// rv_regfile_mp: parametrised multi-port integer register file with clear-on-reset sequencer
module rv_regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int READ_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NREAD*AW-1:0]   i_rs_addr,
  output logic [NREAD*XLEN-1:0] o_rs_data,
  input  logic [AW-1:0]         i_rd,
  input  logic                  i_write,
  input  logic [XLEN-1:0]       i_data,
  output logic                  o_ready,
  input  logic [AW-1:0]         i_dbg_addr,
  output logic [XLEN-1:0]       o_dbg_data
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] mem [NREGS];
  // clear sequencer: walks entries 1..NREGS-1 after every reset, then flags ready
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= CLEAR;
      cnt <= AW'(1);
      o_ready <= 1'b0;
    end else if (state == CLEAR) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(NREGS - 1)) begin
        state <= READY;
        o_ready <= 1'b1;
      end
    end
  end
  // storage write: zeroes during clear, architectural writes only once ready; x0 never written
  always_ff @(posedge i_clk) begin
    if (!i_reset && state == CLEAR)
      mem[cnt] <= '0;
    else if (!i_reset && o_ready && i_write && i_rd != '0)
      mem[i_rd] <= i_data;
  end
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : mem[i_dbg_addr];
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] rs;
    logic [XLEN-1:0] val;
    assign rs = i_rs_addr[k*AW +: AW];
    assign val = (!o_ready || rs == '0) ? '0 :
                 (BYPASS != 0 && i_write && i_rd == rs) ? i_data : mem[rs];
    if (READ_REG != 0) begin : g_q
      logic [XLEN-1:0] q;
      // registered read: one-cycle latency, forced to zero while resetting
      always_ff @(posedge i_clk) q <= i_reset ? '0 : val;
      assign o_rs_data[k*XLEN +: XLEN] = q;
    end else begin : g_c
      assign o_rs_data[k*XLEN +: XLEN] = val;
    end
  end
endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb_rv_regfile_mp: directed checks of clear sequencing, latency, x0, bypass and RV32E restart
module tb_rv_regfile_mp;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, write = 0;
  logic [9:0] rs = '0;
  logic [4:0] rd = '0, dbg = '0;
  logic [31:0] data = '0;
  logic [63:0] a_out, b_out;
  logic a_rdy, b_rdy;
  logic [31:0] a_dbg, b_dbg;
  logic c_reset = 1, c_write = 0;
  logic [7:0] c_rs = '0;
  logic [3:0] c_rd = '0, c_dbgaddr = '0;
  logic [31:0] c_data = '0, c_dbg;
  logic [63:0] c_out;
  logic c_rdy;
  int total = 0, passed = 0, n;

  rv_regfile_mp u_a (.i_clk(clk), .i_reset(reset), .i_rs_addr(rs), .o_rs_data(a_out), .i_rd(rd),
    .i_write(write), .i_data(data), .o_ready(a_rdy), .i_dbg_addr(dbg), .o_dbg_data(a_dbg));
  rv_regfile_mp #(.READ_REG(0), .BYPASS(0)) u_b (.i_clk(clk), .i_reset(reset), .i_rs_addr(rs),
    .o_rs_data(b_out), .i_rd(rd), .i_write(write), .i_data(data), .o_ready(b_rdy),
    .i_dbg_addr(dbg), .o_dbg_data(b_dbg));
  rv_regfile_mp #(.NREGS(16)) u_c (.i_clk(clk), .i_reset(c_reset), .i_rs_addr(c_rs),
    .o_rs_data(c_out), .i_rd(c_rd), .i_write(c_write), .i_data(c_data), .o_ready(c_rdy),
    .i_dbg_addr(c_dbgaddr), .o_dbg_data(c_dbg));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick;
    tick;
    chk("reset_ready_a", 64'(a_rdy), 0);
    chk("reset_ready_b", 64'(b_rdy), 0);
    chk("reset_rs_a", a_out, 0);
    chk("reset_rs_b", b_out, 0);
    reset = 0;
    rs = {5'd3, 5'd3};
    n = 0;
    while (!a_rdy && n < 100) begin
      tick;
      n++;
      if (n == 9) begin
        write = 1; rd = 5'd3; data = 32'hAAAA5555;
      end else write = 0;
      if (!a_rdy) begin
        chk("clear_rs_a", a_out, 0);
        chk("clear_rs_b", b_out, 0);
      end
    end
    write = 0;
    chk("clear_cycles_a", 64'(n), 31);
    chk("clear_ready_b", 64'(b_rdy), 1);
    for (int i = 1; i < 32; i++) begin
      dbg = 5'(i);
      #1;
      chk("dbg_cleared", 64'(a_dbg), 0);
    end
    rs = {5'd0, 5'd3};
    #1;
    chk("blocked_x3_b", b_out, 0);
    tick;
    chk("blocked_x3_a", a_out, 0);
    write = 1; rd = 5'd5; data = 32'hDEADBEEF;
    tick;
    write = 0;
    rs = {5'd0, 5'd5};
    #1;
    chk("x5_comb_b", b_out, 64'h00000000_DEADBEEF);
    chk("x5_not_yet_a", a_out, 0);
    tick;
    chk("x5_reg_a", a_out, 64'h00000000_DEADBEEF);
    write = 1; rd = 5'd0; data = 32'hFFFFFFFF;
    tick;
    write = 0;
    rs = {5'd0, 5'd0};
    dbg = 5'd0;
    #1;
    chk("x0_dbg_a", 64'(a_dbg), 0);
    chk("x0_rs_b", b_out, 0);
    tick;
    chk("x0_rs_a", a_out, 0);
    write = 1; rd = 5'd7; data = 32'h1;
    tick;
    data = 32'h12345678;
    rs = {5'd7, 5'd7};
    #1;
    chk("nobypass_b", b_out, 64'h00000001_00000001);
    tick;
    write = 0;
    chk("bypass_a", a_out, 64'h12345678_12345678);
    chk("after_write_b", b_out, 64'h12345678_12345678);
    c_reset = 0;
    n = 0;
    while (!c_rdy && n < 100) begin
      tick;
      n++;
    end
    chk("c_first_clear", 64'(n), 15);
    c_write = 1; c_rd = 4'd10; c_data = 32'h55;
    tick;
    c_write = 0;
    c_dbgaddr = 4'd10;
    #1;
    chk("c_x10_pre", 64'(c_dbg), 64'h55);
    c_reset = 1;
    tick;
    c_reset = 0;
    chk("c_ready_low", 64'(c_rdy), 0);
    for (int i = 0; i < 7; i++) tick;
    chk("c_x10_partial", 64'(c_dbg), 64'h55);
    c_reset = 1;
    tick;
    c_reset = 0;
    n = 0;
    while (!c_rdy && n < 100) begin
      tick;
      n++;
    end
    chk("c_restart_cycles", 64'(n), 15);
    chk("c_x10_dbg", 64'(c_dbg), 0);
    c_rs = {4'd10, 4'd10};
    tick;
    chk("c_x10_rs", c_out, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rv_regfile_mp.md
Name: rv_regfile_mp

Overview:
Parametrised successor to the core's integer register file, generalised in width, register count and read-port count. It adds a synchronous reset with a self-clearing sequencer, hardwired x0, optional registered reads and an optional write-to-read bypass. It also provides a debug read port. It sits between decode (read addresses), writeback (write port) and the simulation/debug harness.

Parameters:
XLEN, 32, data width in bits (32 or 64)
NREGS, 32, architectural register count; power of two; 32 = RV32I, 16 = RV32E
NREAD, 2, number of independent read ports (1..4)
READ_REG, 1, 1 = registered read data (1-cycle latency); 0 = combinational read
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
AW, $clog2(NREGS), derived register address width (localparam)

Ports:
i_clk  in  1  core clock; all state changes on rising edge
i_reset  in  1  synchronous active-high reset
i_rs_addr  in  NREAD*AW  read addresses; port k at bits [k*AW +: AW]
o_rs_data  out  NREAD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
i_rd  in  AW  write address
i_write  in  1  write enable
i_data  in  XLEN  write data
o_ready  out  1  high once clear sequence is done; writes accepted only when high
i_dbg_addr  in  AW  debug read address
o_dbg_data  out  XLEN  debug read data; combinational; never bypassed

Behaviour:
- Storage: entries 1..NREGS-1. Address 0 always reads 0. Writes to address 0 are dropped.
- States: CLEAR, READY.
- While i_reset=1 (sampled at edge):
  - state<=CLEAR, clear counter<=1, o_ready<=0.
  - Registered o_rs_data<=0.
  - Writes are ignored.
- CLEAR with i_reset=0:
  - Each cycle write 0 to entry[counter], then counter++.
  - When counter==NREGS-1 is written, go to READY and set o_ready<=1.
  - Clear takes exactly NREGS-1 cycles after reset deasserts (31 for NREGS=32).
- Reset asserted mid-CLEAR or in READY: restart from counter=1. All contents are re-cleared.
- During CLEAR:
  - i_write is ignored. No bypass.
  - All o_rs_data ports read 0.
  - o_dbg_data shows live storage, including partially cleared entries.
- READY write: at the edge where i_write=1 and i_rd!=0, entry[i_rd]<=i_data.
- Read value for port k (rs = its address):
  - rs==0 -> 0.
  - Else if BYPASS=1, i_write=1, o_ready=1 and i_rd==rs -> i_data.
  - Else entry[rs].
- READ_REG=1: the read value is captured at the edge, so o_rs_data is valid the cycle after the address is presented.
- READ_REG=0: the read value is driven combinationally in the same cycle.
- BYPASS=0: a same-cycle read of the register being written returns the old value (READ_REG=0) or the old value captured at that edge (READ_REG=1).
- Multiple read ports addressing the same register all return identical data. Ports are independent; there are no port conflicts.
- Reset values:
  - o_ready=0.
  - o_rs_data=0 (both READ_REG modes, since CLEAR forces 0).
  - o_dbg_data reflects storage; it is 0 for address 0 and X-free once CLEAR is complete.
- No X propagation after CLEAR: every entry has been written.

Test Plan:
- Reset clear: NREGS=32. Hold i_reset 2 cycles, release; poll o_ready -> o_ready rises exactly 31 cycles after release. Debug reads of x1..x31 all return 0.
- Write/read latency: READ_REG=1, READY. Write x5=0xDEADBEEF; next cycle rs0=5 -> o_rs_data port0 = 0xDEADBEEF one cycle later. Also set rs1=0 -> port1 = 0.
- x0 hardwired: write x0=0xFFFFFFFF, then read rs0=0 -> 0. o_dbg_data at address 0 -> 0.
- Bypass: BYPASS=1. Same cycle write x7=0x12345678 and rs0=rs1=7 -> both ports return 0x12345678. Repeat with BYPASS=0 after x7=0x1 -> both return 0x1.
- Writes blocked in CLEAR: i_write=1, i_rd=3, i_data=0xAAAA5555 during the 10th clear cycle -> after READY, x3 reads 0. All o_rs_data = 0 throughout CLEAR.
- Reset mid-clear and RV32E: NREGS=16. Assert i_reset at the 8th clear cycle, release -> o_ready rises 15 cycles after the second release. Preloaded x10=0x55 reads 0.
